branch_predictor: RTL and testbench

- Supplies the fetch stage's branch-prediction inputs (predicted-taken flag and predicted target) for the current fetch PC.
- Learns from branch resolutions reported back from EX.
- Direct-mapped BTB; each entry holds a valid bit, a tag, a target and a 2-bit saturating direction counter.
- Also keeps performance counters for resolved branches and mispredictions.

---
 rtl/branch_predictor.sv | 101 ++++++++++
 tb/tb_branch_predictor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating direction counters.
// Lookup is combinational from pc_i. EX resolutions update the table at the clock edge.
// There is no bypass, so a same-cycle lookup of the entry being written sees the old contents.
// Saturating counters track resolved branches and mispredictions.
module branch_predictor #(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned IDX_W   = 4,
   parameter int unsigned TAG_W   = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   output logic        pred_taken_o,
   output logic [31:0] pred_target_o,
   input  logic        ex_valid_i,
   input  logic        ex_is_br_i,
   input  logic [31:0] ex_pc_i,
   input  logic        ex_br_taken_i,
   input  logic [31:0] ex_br_target_i,
   input  logic        ex_mispredict_i,
   output logic [31:0] br_cnt_o,
   output logic [31:0] mispred_cnt_o
);

   logic             r_valid  [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [31:0]      r_target [ENTRIES];
   logic [1:0]       r_ctr    [ENTRIES];
   logic [31:0]      r_br_cnt;
   logic [31:0]      r_mispred_cnt;

   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic             w_hit;
   logic [IDX_W-1:0] w_eidx;
   logic [TAG_W-1:0] w_etag;
   logic             w_ehit;
   logic             w_upd;
   logic [3:0]       w_unused_pc_bits;

   assign w_idx  = pc_i[IDX_W+1:2];
   assign w_tag  = pc_i[31:IDX_W+2];
   assign w_eidx = ex_pc_i[IDX_W+1:2];
   assign w_etag = ex_pc_i[31:IDX_W+2];
   assign w_upd  = ex_valid_i && ex_is_br_i;
   // Word-aligned PCs: the byte-offset bits play no part in indexing or tagging.
   assign w_unused_pc_bits = {pc_i[1:0], ex_pc_i[1:0]};

   // Fetch-side lookup: hit and taken-prediction from the current table contents
   always_comb begin
      w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
      pred_taken_o  = w_hit && r_ctr[w_idx][1];
      pred_target_o = pred_taken_o ? r_target[w_idx] : '0;
   end

   // EX-side tag match on the entry being resolved
   always_comb begin
      w_ehit = r_valid[w_eidx] && (r_tag[w_eidx] == w_etag);
   end

   // Table update: train on hit, allocate on taken miss, ignore not-taken miss
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b01;
         end
      end else if (w_upd) begin
         if (w_ehit) begin
            if (ex_br_taken_i) begin
               if (r_ctr[w_eidx] != 2'b11) r_ctr[w_eidx] <= r_ctr[w_eidx] + 2'b01;
               r_target[w_eidx] <= ex_br_target_i;
            end else begin
               if (r_ctr[w_eidx] != 2'b00) r_ctr[w_eidx] <= r_ctr[w_eidx] - 2'b01;
            end
         end else if (ex_br_taken_i) begin
            r_valid[w_eidx]  <= 1'b1;
            r_tag[w_eidx]    <= w_etag;
            r_target[w_eidx] <= ex_br_target_i;
            r_ctr[w_eidx]    <= 2'b10;
         end
      end
   end

   // Performance counters, saturating at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_br_cnt      <= '0;
         r_mispred_cnt <= '0;
      end else if (w_upd) begin
         if (r_br_cnt != '1) r_br_cnt <= r_br_cnt + 32'd1;
         if (ex_mispredict_i && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
   end

   assign br_cnt_o      = r_br_cnt;
   assign mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench with a behavioural BTB model, directed and random stimulus.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_i = '0;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic        ex_valid_i = 1'b0;
   logic        ex_is_br_i = 1'b0;
   logic [31:0] ex_pc_i = '0;
   logic        ex_br_taken_i = 1'b0;
   logic [31:0] ex_br_target_i = '0;
   logic        ex_mispredict_i = 1'b0;
   logic [31:0] br_cnt_o;
   logic [31:0] mispred_cnt_o;

   branch_predictor #(.ENTRIES(16), .IDX_W(4), .TAG_W(26)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i),
      .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
      .ex_valid_i(ex_valid_i), .ex_is_br_i(ex_is_br_i), .ex_pc_i(ex_pc_i),
      .ex_br_taken_i(ex_br_taken_i), .ex_br_target_i(ex_br_target_i),
      .ex_mispredict_i(ex_mispredict_i),
      .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic        pt;
      logic [31:0] tgt;
      logic [31:0] bc;
      logic [31:0] mc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;

   // Reference model: per-slot owner address, stored target and confidence level 0..3
   bit          m_valid [16];
   longint      m_owner [16];
   logic [31:0] m_tgt   [16];
   int          m_conf  [16];
   longint      m_br;
   longint      m_mp;
   localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

   function automatic int slot_of(input logic [31:0] a);
      return int'((a / 4) % 16);
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      int s;
      s = slot_of(a);
      return m_valid[s] && ((m_owner[s] / 64) == (longint'(a) / 64));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_owner[i] = 0;
         m_tgt[i]   = '0;
         m_conf[i]  = 1;
      end
      m_br = 0;
      m_mp = 0;
   endtask

   task automatic model_update(input logic v, br, tk, input logic [31:0] epc, tgt, input logic mp);
      int s;
      if (!(v && br)) return;
      if (m_br < SAT) m_br++;
      if (mp && m_mp < SAT) m_mp++;
      s = slot_of(epc);
      if (model_hit(epc)) begin
         if (tk) begin
            m_conf[s] = (m_conf[s] + 1 > 3) ? 3 : m_conf[s] + 1;
            m_tgt[s]  = tgt;
         end else begin
            m_conf[s] = (m_conf[s] - 1 < 0) ? 0 : m_conf[s] - 1;
         end
      end else if (tk) begin
         m_valid[s] = 1'b1;
         m_owner[s] = longint'(epc);
         m_tgt[s]   = tgt;
         m_conf[s]  = 2;
      end
   endtask

   // One cycle of stimulus: drive, record the expected response, then advance the model
   task automatic step(input logic [31:0] pc, input logic v, br, tk,
                       input logic [31:0] epc, tgt, input logic mp);
      exp_t e;
      int   s;
      @(posedge clk);
      #1;
      pc_i = pc; ex_valid_i = v; ex_is_br_i = br; ex_pc_i = epc;
      ex_br_taken_i = tk; ex_br_target_i = tgt; ex_mispredict_i = mp;
      s      = slot_of(pc);
      e.id   = step_id++;
      e.pt   = model_hit(pc) && (m_conf[s] >= 2);
      e.tgt  = e.pt ? m_tgt[s] : 32'h0;
      e.bc   = m_br[31:0];
      e.mc   = m_mp[31:0];
      q.push_back(e);
      if (!rst) model_update(v, br, tk, epc, tgt, mp);
   endtask

   task automatic idle(input logic [31:0] pc);
      step(pc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   // Asynchronous reset raised mid-cycle while an update may be pending, then released
   task automatic reset_pulse();
      @(negedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      idle(32'h100);
      idle(32'h0);
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic rand_phase(input int n);
      logic [31:0] a, b;
      for (int k = 0; k < n; k++) begin
         a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         b = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 2) == 0) a = b;
         step(a, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
              $urandom_range(0, 1) == 1, b, $urandom, $urandom_range(0, 1) == 1);
      end
   endtask

   task automatic cmp(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step=%0d got=%h exp=%h", name, id, got, exp);
      end
   endtask

   // Monitor: outputs are sampled at the falling edge and checked against the queue head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            cmp("pred_taken", e.id, {31'h0, pred_taken_o}, {31'h0, e.pt});
            cmp("pred_target", e.id, pred_target_o, e.tgt);
            cmp("br_cnt", e.id, br_cnt_o, e.bc);
            cmp("mispred_cnt", e.id, mispred_cnt_o, e.mc);
         end
      end
   end

   initial begin
      int budget;
      model_reset();
      idle(32'h0);
      idle(32'h100);
      @(negedge clk);
      #1;
      rst = 1'b0;

      rand_phase(150);

      // Reset mid-run with an update on the EX inputs, then sweep the first 16 PCs
      step(32'h0, 1'b1, 1'b1, 1'b1, 32'h4, 32'h1234, 1'b1);
      reset_pulse();
      for (int a = 0; a <= 'h3C; a += 4) idle(32'(a));

      // Allocation; the lookup in the update cycle still sees the old entry
      step(32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'h080, 1'b1);
      idle(32'h100);

      // Hysteresis and saturation
      for (int k = 0; k < 3; k++) step(32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'h080, 1'b0);
      step(32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 32'h999, 1'b1);
      idle(32'h100);
      step(32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 32'h999, 1'b1);
      idle(32'h100);
      step(32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'h080, 1'b1);
      idle(32'h100);

      // Aliasing on slot 0
      idle(32'h140);
      step(32'h140, 1'b1, 1'b1, 1'b1, 32'h140, 32'h200, 1'b0);
      idle(32'h140);
      idle(32'h100);

      // No allocation on a not-taken miss
      step(32'h104, 1'b1, 1'b1, 1'b0, 32'h104, 32'h300, 1'b0);
      idle(32'h104);

      // Gating by ex_valid_i and ex_is_br_i
      step(32'h108, 1'b0, 1'b1, 1'b1, 32'h108, 32'h400, 1'b1);
      idle(32'h108);
      step(32'h108, 1'b1, 1'b0, 1'b1, 32'h108, 32'h400, 1'b1);
      idle(32'h108);

      // Target low bits stored unmodified
      step(32'h10C, 1'b1, 1'b1, 1'b1, 32'h10C, 32'h0000_0203, 1'b0);
      idle(32'h10C);

      rand_phase(300);
      idle(32'h0);

      budget = 20;
      while (q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      @(posedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
